pll_lock_sequencer: RTL and testbench

Lock-qualification and reset sequencer that sits directly downstream of the system PLL wrapper. It consumes the PLL `locked` flag, drives the PLL `rst` input, and issues the design-wide reset and `ready` only after lock has been stable for a programmable time. On lock timeout it re-pulses the PLL reset and retries. It runs on the free-running 50 MHz board reference clock, so it keeps operating while the PLL output is absent.

---
 rtl/pll_lock_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock qualification and reset sequencer on the free-running reference clock.
// Optional build macro LOCKSEQ_STATS_EN compiles in the retry / lock-loss statistics counters.
module pll_lock_sequencer #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_stats,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state_dbg
);

  localparam int MAX_A = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_QUALIFY   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, lock_s;
  logic          retry_inc, loss_inc;

  // Two-flop synchronizer: the only place pll_locked is sampled.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lock_s <= sync_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock has priority over a coincident timeout.
        if (lock_s) begin
          state_d = S_QUALIFY;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      S_QUALIFY: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d  = S_WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are loaded from the next state so they track the registered state exactly.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= (state_d == S_PLL_RST);
      sys_rst_n <= (state_d == S_RUN);
      ready     <= (state_d == S_RUN);
    end
  end

  assign state_dbg = state_q;

`ifdef LOCKSEQ_STATS_EN
  logic [7:0] retry_q, loss_q;

  // Clear wins over a same-edge increment; both counters stick at 255.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
    end else if (clear_stats) begin
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
    end else begin
      if (retry_inc && (retry_q != 8'hFF)) retry_q <= retry_q + 8'd1;
      if (loss_inc && (loss_q != 8'hFF))   loss_q  <= loss_q + 8'd1;
    end
  end

  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
`else
  logic unused_stats;
  assign unused_stats    = ^{clear_stats, retry_inc, loss_inc};
  assign retry_count     = 8'd0;
  assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with STABLE=4, TIMEOUT=20, PLL_RST=3.
// Counter expectations follow whether LOCKSEQ_STATS_EN is defined for the build.
module tb_pll_lock_sequencer;

`ifdef LOCKSEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  localparam logic [1:0] ST_PLL_RST = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_QUAL    = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  logic       refclk = 1'b0;
  logic       rst, pll_locked, clear_stats;
  logic       pll_rst, sys_rst_n, ready;
  logic [7:0] retry_count, lock_loss_count;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(20),
    .PLL_RST_CYCLES(3)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .clear_stats    (clear_stats),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int v);
    return STATS_EN ? 32'(v) : 32'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Consecutive samples (current one included) where pll_rst equals lvl.
  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while ((pll_rst === lvl) && (n < 1000)) begin
      n++;
      tick();
    end
  endtask

  // Edges until ready rises; also reports whether pll_rst was seen high.
  task automatic wait_ready(output int n, output logic saw_rst);
    n = 0;
    saw_rst = 1'b0;
    do begin
      tick();
      n++;
      if (pll_rst) saw_rst = 1'b1;
    end while (!ready && (n < 200));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_state"}, state_dbg, ST_PLL_RST);
    check({tag, "_retry"}, retry_count, 0);
    check({tag, "_loss"}, lock_loss_count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    int   r;
    logic saw;
    logic prev;

    rst = 1'b0;
    pll_locked = 1'b0;
    clear_stats = 1'b0;
    tick();
    tick();
    check_reset_values("por");

    // Lock present from the start.
    pll_locked = 1'b1;
    tick();
    rst = 1'b1;
    count_while(1'b1, n);
    check("lk_pulse_w", n, 3);
    wait_ready(n, saw);
    check("lk_rel_lat", n, 5);
    check("lk_sys_rst_n", sys_rst_n, 1);
    check("lk_state", state_dbg, ST_RUN);
    check("lk_retry", retry_count, 0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick();
    check("loss_e0_ready", ready, 1);
    tick();
    check("loss_e1_sys", sys_rst_n, 1);
    tick();
    check("loss_e2_sys", sys_rst_n, 0);
    check("loss_e2_ready", ready, 0);
    check("loss_e2_pll_rst", pll_rst, 0);
    check("loss_e2_state", state_dbg, ST_WAIT);
    check("loss_cnt", lock_loss_count, exp_stat(1));

    // Brief lock: two QUALIFY cycles, then a 3-cycle drop.
    pll_locked = 1'b1;
    tick();
    tick();
    pll_locked = 1'b0;
    tick();
    check("gl_qual0", state_dbg, ST_QUAL);
    tick();
    check("gl_qual1", state_dbg, ST_QUAL);
    tick();
    check("gl_back_wait", state_dbg, ST_WAIT);
    check("gl_ready", ready, 0);
    pll_locked = 1'b1;
    wait_ready(n, saw);
    check("gl_rel_lat", n, 7);
    check("gl_no_pll_rst", saw, 0);
    check("gl_loss_cnt", lock_loss_count, exp_stat(1));

    // Lock loss with clear_stats on the increment edge.
    pll_locked = 1'b0;
    tick();
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clr_ready", ready, 0);
    check("clr_loss_cnt", lock_loss_count, 0);
    pll_locked = 1'b1;
    wait_ready(n, saw);
    check("relock_lat", n, 7);
    check("relock_no_pll_rst", saw, 0);

    // Reset in RUN.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_values("run_rst");
    count_while(1'b1, n);
    check("run_rst_pulse_w", n, 3);
    wait_ready(n, saw);
    check("run_rst_rel_lat", n, 5);

    // Permanent no-lock: retries and saturation.
    pll_locked = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    count_while(1'b1, n);
    check("nl_pulse0_w", n, 3);
    for (int k = 1; k <= 3; k++) begin
      count_while(1'b0, n);
      check("nl_gap", n, 20);
      check("nl_retry", retry_count, exp_stat(k));
      count_while(1'b1, n);
      check("nl_pulse_w", n, 3);
    end
    check("nl_sys_rst_n", sys_rst_n, 0);
    r = 3;
    prev = pll_rst;
    for (int i = 0; (i < 8000) && (r < 300); i++) begin
      tick();
      if (pll_rst && !prev) begin
        r++;
        if (r == 255) check("sat_255", retry_count, exp_stat(255));
        if (r == 256) check("sat_256", retry_count, exp_stat(255));
      end
      prev = pll_rst;
    end
    check("nl_retries", r, 300);
    check("sat_300", retry_count, exp_stat(255));
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clr_retry", retry_count, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
